// File: rtl/cpu_pkg.sv
// Shared types and constants for the 8-bit CPU control path: opcode and
// sequencer state encodings plus instruction field positions.
package cpu_pkg;

   localparam int REG_ADDR_W = 4;
   localparam int DATA_W     = 8;

   localparam int OPC_HI = 15;
   localparam int OPC_LO = 12;
   localparam int FA_HI  = 11;
   localparam int FA_LO  = 8;
   localparam int FB_HI  = 7;
   localparam int FB_LO  = 4;
   localparam int FC_HI  = 3;
   localparam int FC_LO  = 0;
   localparam int TGT_HI = 7;
   localparam int TGT_LO = 0;

   typedef enum logic [3:0] {
      OP_NOP       = 4'h0,
      OP_ALU_FIRST = 4'h1,
      OP_ALU_LAST  = 4'hC,
      OP_JMP       = 4'hD,
      OP_JZ        = 4'hE,
      OP_HALT      = 4'hF
   } opcode_e;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_DECODE    = 3'd2,
      S_EXECUTE   = 3'd3,
      S_WRITEBACK = 3'd4,
      S_HALT      = 3'd5
   } state_e;

   function automatic logic is_alu(input logic [3:0] op);
      return (op >= OP_ALU_FIRST) && (op <= OP_ALU_LAST);
   endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter register: load has priority over increment; wraps modulo
// 2^PC_W on increment.
module program_counter #(
   parameter int PC_W = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            inc,
   input  logic            load,
   input  logic [PC_W-1:0] load_val,
   output logic [PC_W-1:0] pc
);

   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] pc_d;

   always_comb begin
      pc_d = pc_q;
      if (load)
         pc_d = load_val;
      else if (inc)
         pc_d = pc_q + PC_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pc_q <= '0;
      else
         pc_q <= pc_d;
   end

   assign pc = pc_q;

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer: owns PC and IR, fetches from a
// one-cycle-latency ROM and drives register-file addresses, write strobe and ALU op.
module control_unit
   import cpu_pkg::*;
#(
   parameter int PC_W    = 8,
   parameter int INSTR_W = 16
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  start,
   input  logic [INSTR_W-1:0]    imem_data,
   input  logic [DATA_W-1:0]     RD1,
   output logic [PC_W-1:0]       imem_addr,
   output logic                  imem_en,
   output logic [REG_ADDR_W-1:0] RA1,
   output logic [REG_ADDR_W-1:0] RA2,
   output logic [REG_ADDR_W-1:0] WA,
   output logic [3:0]            alu_op,
   output logic                  write_enable,
   output logic                  halted
);

   state_e             state_q, state_d;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic [PC_W-1:0]    pc;
   logic               pc_inc;
   logic               pc_load;
   logic [3:0]         opc;
   logic [PC_W-1:0]    jmp_tgt;

   assign opc     = ir_q[OPC_HI:OPC_LO];
   assign jmp_tgt = PC_W'(ir_q[TGT_HI:TGT_LO]);

   program_counter #(.PC_W(PC_W)) u_pc (
      .clk      (CLK),
      .rst      (RST),
      .inc      (pc_inc),
      .load     (pc_load),
      .load_val (jmp_tgt),
      .pc       (pc)
   );

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      pc_inc  = 1'b0;
      pc_load = 1'b0;
      case (state_q)
         S_IDLE:      if (start) state_d = S_FETCH;
         S_FETCH:     state_d = S_DECODE;
         S_DECODE: begin
            ir_d    = imem_data;
            pc_inc  = 1'b1;
            state_d = S_EXECUTE;
         end
         S_EXECUTE: begin
            // Jump load lands one edge after the DECODE increment, so it wins.
            if (opc == OP_JMP)
               pc_load = 1'b1;
            else if (opc == OP_JZ && RD1 == '0)
               pc_load = 1'b1;
            if (is_alu(opc))
               state_d = S_WRITEBACK;
            else if (opc == OP_HALT)
               state_d = S_HALT;
            else
               state_d = S_FETCH;
         end
         S_WRITEBACK: state_d = S_FETCH;
         S_HALT:      state_d = S_HALT;
         default:     state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   // Strobes decode straight from state so RST clears them without a clock.
   always_comb begin
      imem_en      = (state_q == S_FETCH);
      write_enable = (state_q == S_WRITEBACK);
      halted       = (state_q == S_HALT);
      imem_addr    = pc;
      WA           = ir_q[FA_HI:FA_LO];
      RA1          = (opc == OP_JZ) ? ir_q[FA_HI:FA_LO] : ir_q[FB_HI:FB_LO];
      RA2          = ir_q[FC_HI:FC_LO];
      alu_op       = is_alu(opc) ? opc : 4'h0;
   end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios plus random
// programs checked against an instruction-level model of the sequencer.
module tb_control_unit;

   logic        CLK;
   logic        RST;
   logic        start;
   logic [15:0] imem_data;
   logic [7:0]  RD1;
   logic [7:0]  imem_addr;
   logic        imem_en;
   logic [3:0]  RA1, RA2, WA, alu_op;
   logic        write_enable;
   logic        halted;

   logic [15:0] rom [256];
   int          n_cmp = 0;
   int          n_err = 0;
   int          mpc;
   bit          mhalted;

   control_unit #(.PC_W(8), .INSTR_W(16)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .start        (start),
      .imem_data    (imem_data),
      .RD1          (RD1),
      .imem_addr    (imem_addr),
      .imem_en      (imem_en),
      .RA1          (RA1),
      .RA2          (RA2),
      .WA           (WA),
      .alu_op       (alu_op),
      .write_enable (write_enable),
      .halted       (halted)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Synchronous ROM with one cycle of read latency.
   always @(posedge CLK) if (imem_en) imem_data <= rom[imem_addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_en"},  32'(imem_en), 0);
      chk({tag, "_we"},  32'(write_enable), 0);
      chk({tag, "_hlt"}, 32'(halted), 0);
      chk({tag, "_pc"},  32'(imem_addr), 0);
      chk({tag, "_ra1"}, 32'(RA1), 0);
      chk({tag, "_ra2"}, 32'(RA2), 0);
      chk({tag, "_wa"},  32'(WA), 0);
      chk({tag, "_op"},  32'(alu_op), 0);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b1;
      start = 1'b0;
      @(negedge CLK);
      RST = 1'b0;
      mpc = 0;
      mhalted = 1'b0;
   endtask

   // Leaves the bench at the negedge of the first FETCH cycle.
   task automatic start_cpu();
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
   endtask

   // One instruction at ISA level: what it reads/writes, how long it takes,
   // and where the next fetch must come from.
   task automatic exec_one(input logic [7:0] rd1);
      logic [15:0] ins;
      logic [3:0]  op, a, b, c;
      bit          alu;
      ins = rom[mpc];
      op = ins[15:12]; a = ins[11:8]; b = ins[7:4]; c = ins[3:0];
      alu = (op >= 1) && (op <= 12);
      chk("fetch_en", 32'(imem_en), 1);
      chk("fetch_addr", 32'(imem_addr), 32'(mpc));
      chk("fetch_we", 32'(write_enable), 0);
      @(negedge CLK);
      RD1 = rd1;
      chk("dec_en", 32'(imem_en), 0);
      @(negedge CLK);
      chk("ex_ra1", 32'(RA1), (op == 14) ? 32'(a) : 32'(b));
      chk("ex_ra2", 32'(RA2), 32'(c));
      chk("ex_wa", 32'(WA), 32'(a));
      chk("ex_op", 32'(alu_op), alu ? 32'(op) : 0);
      chk("ex_we", 32'(write_enable), 0);
      mpc = (mpc + 1) % 256;
      if (op == 13 || (op == 14 && rd1 == 8'h00)) mpc = int'(ins[7:0]);
      if (alu) begin
         @(negedge CLK);
         chk("wb_we", 32'(write_enable), 1);
         chk("wb_ra1", 32'(RA1), 32'(b));
         chk("wb_ra2", 32'(RA2), 32'(c));
         chk("wb_op", 32'(alu_op), 32'(op));
      end
      @(negedge CLK);
      if (op == 15) begin
         chk("halt_flag", 32'(halted), 1);
         chk("halt_en", 32'(imem_en), 0);
         mhalted = 1'b1;
      end else begin
         chk("run_flag", 32'(halted), 0);
      end
   endtask

   initial begin
      RST = 1'b1;
      start = 1'b0;
      RD1 = 8'h00;
      for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
      #1;
      chk_reset_vals("rst");

      // ALU op then NOP from address 1
      rom[0] = 16'h1312;
      do_reset();
      chk_reset_vals("idle");
      start_cpu();
      exec_one(8'h55);
      exec_one(8'h00);
      chk("after_nop_addr", 32'(imem_addr), 2);

      // JMP 5
      rom[0] = 16'hD005;
      do_reset();
      start_cpu();
      exec_one(8'h00);
      chk("jmp_addr", 32'(imem_addr), 5);

      // JZ taken and not taken
      rom[0] = 16'hE20A;
      do_reset();
      start_cpu();
      exec_one(8'h00);
      chk("jz_taken", 32'(imem_addr), 10);
      do_reset();
      start_cpu();
      exec_one(8'h01);
      chk("jz_not_taken", 32'(imem_addr), 1);

      // HALT: start ignored, reset recovers
      rom[0] = 16'hF000;
      do_reset();
      start_cpu();
      exec_one(8'h00);
      for (int k = 0; k < 3; k++) begin
         start = 1'b1;
         @(negedge CLK);
         start = 1'b0;
         @(negedge CLK);
         chk("halt_hold", 32'(halted), 1);
         chk("halt_no_fetch", 32'(imem_en), 0);
         chk("halt_pc", 32'(imem_addr), 1);
      end
      do_reset();
      chk_reset_vals("halt_rst");

      // PC wrap through address 255
      rom[0] = 16'hD0FF;
      rom[255] = 16'h0000;
      do_reset();
      start_cpu();
      exec_one(8'h00);
      exec_one(8'h00);
      chk("wrap_addr", 32'(imem_addr), 0);

      // Reset landing in WRITEBACK
      rom[0] = 16'h1312;
      do_reset();
      start_cpu();
      @(negedge CLK);
      @(negedge CLK);
      @(negedge CLK);
      chk("mid_wb_we", 32'(write_enable), 1);
      #2 RST = 1'b1;
      #1 chk_reset_vals("mid_rst");
      @(negedge CLK);
      RST = 1'b0;
      mpc = 0;
      mhalted = 1'b0;
      start_cpu();
      exec_one(8'h00);

      // Random programs
      for (int s = 0; s < 6; s++) begin
         for (int i = 0; i < 256; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 14));
            if ($urandom_range(0, 99) < 2) op = 4'hF;
            rom[i] = {op, 12'($urandom)};
         end
         do_reset();
         start_cpu();
         for (int k = 0; k < 60 && !mhalted; k++)
            exec_one(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
